sfft_pingpong_buffer: RTL
=========================

Name: sfft_pingpong_buffer

Overview:
- Parametrised two-bank (ping-pong) complex-sample buffer placed between consecutive SFFT pipeline stages.
- The producer stage fills one bank through two write ports (butterfly pair A/B) while the consumer stage drains the other bank through two read ports.
- Bank ownership is exchanged by a done/ready handshake, so stages overlap frame-by-frame without address collisions.
- Successor to the single-bank dual-port pipeline RAM: it adds banking, handshake, configurable read latency, read-valid tracking and error flags.

Parameters:
- DATA_WIDTH, 16 (`SFFT_OUTPUT_WIDTH): width of each real/imag word.
- ADDR_WIDTH, 9 (`nFFT): per-bank address width; depth = 2**ADDR_WIDTH (`NFFT).
- READ_LATENCY, 1: 1 = registered RAM read; 2 = adds an output register. Any other value is a compile-time error.

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- wr_ready  out  1  a bank is owned by the producer
- wr_en_A / wr_en_B  in  1  write strobe per port
- wr_addr_A / wr_addr_B  in  ADDR_WIDTH  write address within the producer bank
- wr_real_A / wr_imag_A / wr_real_B / wr_imag_B  in  DATA_WIDTH  write data
- wr_done  in  1  one-cycle pulse: producer bank complete
- rd_avail  out  1  a full bank is owned by the consumer
- rd_en_A / rd_en_B  in  1  read strobe per port
- rd_addr_A / rd_addr_B  in  ADDR_WIDTH  read address within the consumer bank
- rd_real_A / rd_imag_A / rd_real_B / rd_imag_B  out  DATA_WIDTH  read data
- rd_valid_A / rd_valid_B  out  1  read data valid this cycle
- rd_done  in  1  one-cycle pulse: consumer finished with its bank
- err_wr / err_rd  out  1  sticky protocol-error flags

Behaviour:
- State registers: wb (write-bank index, 1 bit), rb (read-bank index, 1 bit), full_cnt (0..2).
- Reset: wb=rb=0, full_cnt=0, all rd_* outputs 0, rd_valid_* 0, err_* 0. RAM contents are not cleared.
- Outputs: wr_ready = (full_cnt != 2); rd_avail = (full_cnt != 0). Both are combinational from registers.
- Write: when wr_en_X & wr_ready, mem[{wb, wr_addr_X}] <= data at the clock edge.
  - A and B writing the same address in the same cycle: port B wins.
  - wr_en_X while !wr_ready: write dropped, err_wr set.
- wr_done & wr_ready: wb toggles, full_cnt+1. wr_done & !wr_ready: ignored, err_wr set.
- Read: rd_en_X & rd_avail issues a read of mem[{rb, rd_addr_X}]. The bank bit is captured at issue, so a read in flight across a bank swap returns the old bank's data.
  - Data and rd_valid_X appear READ_LATENCY cycles after issue.
  - rd_en_X while !rd_avail: no valid is produced, err_rd set.
  - Data outputs hold their last value while valid is low.
- rd_done & rd_avail: rb toggles, full_cnt-1. rd_done & !rd_avail: ignored, err_rd set.
- Simultaneous accepted wr_done and rd_done: both indices toggle, full_cnt unchanged.
- Invariant: while full_cnt==1, wb != rb, so read and write never touch the same bank. At full_cnt==0 reads are blocked; at full_cnt==2 writes are blocked.
- Same-cycle write and done: a write in the same cycle as the accepted wr_done lands in the old bank. A read in the same cycle as the accepted rd_done reads the old bank.
- Reset asserted mid-frame: takes effect on the next edge, and in-flight rd_valid pipeline stages are cleared.
- err_wr / err_rd: cleared only by reset.

Decomposition:
- Package sfft_buffer_pkg:
  - complex_t packed struct {real, imag} of `SFFT_OUTPUT_WIDTH
  - bank_idx_t
  - localparam NUM_BANKS = 2
- Sub-module complex_dp_ram:
  - true dual-port RAM, 2**(ADDR_WIDTH+1) complex words, registered read, port-B-wins write
  - top level adds the bank bit as address MSB, plus handshake counters, READ_LATENCY pipe and error flags
- Target: roughly 200 RTL lines total.

Test Plan:
- Reset, then fill bank 0: write addr 0..511 with real=addr, imag=~addr, pulse wr_done -> rd_avail=1, wr_ready=1, full_cnt=1. Read addr 5 on A -> rd_real_A=5, rd_imag_A=~5, rd_valid_A exactly READ_LATENCY cycles later (test both 1 and 2).
- Fill both banks without rd_done -> wr_ready=0. Further wr_en at addr 3 is dropped and err_wr=1. Bank 0 still reads its original addr 3 value.
- Same-cycle wr_en_A/wr_en_B to addr 7 with A=0x1111, B=0x2222 -> later read returns 0x2222.
- With full_cnt=1, pulse wr_done and rd_done in the same cycle -> full_cnt stays 1, wb and rb both toggle, and the next read returns the newly completed frame.
- Issue a read on A, then assert rd_done the following cycle (READ_LATENCY=2) -> returned data comes from the old bank; no rd_valid for reads issued after rd_avail drops to 0.
- Assert reset mid-stream with reads in flight -> next cycle rd_valid_A/B=0, wr_ready=1, rd_avail=0, err_wr=err_rd=0.

Source files
------------

// File: rtl/sfft_buffer_pkg.sv
// -----------------------------------------------------------------------------
// sfft_buffer_pkg
// Shared types and constants for the SFFT inter-stage ping-pong buffer.
//   SFFT_OUTPUT_WIDTH : default width of one real or imaginary word
//   NUM_BANKS         : number of frame banks (ping + pong)
//   bank_idx_t        : index selecting one bank
//   complex_t         : one complex sample {re, im}
// -----------------------------------------------------------------------------
package sfft_buffer_pkg;

    localparam int SFFT_OUTPUT_WIDTH = 16;
    localparam int NUM_BANKS         = 2;

    typedef logic [$clog2(NUM_BANKS)-1:0] bank_idx_t;

    typedef struct packed {
        logic signed [SFFT_OUTPUT_WIDTH-1:0] re;
        logic signed [SFFT_OUTPUT_WIDTH-1:0] im;
    } complex_t;

endpackage

// File: rtl/complex_dp_ram.sv
// -----------------------------------------------------------------------------
// complex_dp_ram
// Two-write / two-read RAM of complex words with registered read data.
//   clk, reset             : clock, synchronous active-high reset (read regs)
//   we_a_i/waddr_a_i/wdata_a_i, we_b_i/waddr_b_i/wdata_b_i : write ports
//   re_a_i/raddr_a_i/rdata_a_o, re_b_i/raddr_b_i/rdata_b_o : read ports
// Word layout is {real, imag}. Read data holds until the next read strobe.
// -----------------------------------------------------------------------------
module complex_dp_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we_a_i,
    input  logic [ADDR_WIDTH-1:0]   waddr_a_i,
    input  logic [2*DATA_WIDTH-1:0] wdata_a_i,
    input  logic                    we_b_i,
    input  logic [ADDR_WIDTH-1:0]   waddr_b_i,
    input  logic [2*DATA_WIDTH-1:0] wdata_b_i,
    input  logic                    re_a_i,
    input  logic [ADDR_WIDTH-1:0]   raddr_a_i,
    output logic [2*DATA_WIDTH-1:0] rdata_a_o,
    input  logic                    re_b_i,
    input  logic [ADDR_WIDTH-1:0]   raddr_b_i,
    output logic [2*DATA_WIDTH-1:0] rdata_b_o
);

    logic [2*DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [2*DATA_WIDTH-1:0] rdata_a_q;
    logic [2*DATA_WIDTH-1:0] rdata_b_q;

    // Port B is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (we_a_i) mem_q[waddr_a_i] <= wdata_a_i;
        if (we_b_i) mem_q[waddr_b_i] <= wdata_b_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            if (re_a_i) rdata_a_q <= mem_q[raddr_a_i];
            if (re_b_i) rdata_b_q <= mem_q[raddr_b_i];
        end
    end

    assign rdata_a_o = rdata_a_q;
    assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/sfft_pingpong_buffer.sv
// -----------------------------------------------------------------------------
// sfft_pingpong_buffer
// Two-bank complex-sample buffer between consecutive SFFT stages. The producer
// fills bank wb through write ports A/B while the consumer drains bank rb
// through read ports A/B; banks are exchanged with wr_done / rd_done pulses.
//   clk, reset                       : clock, synchronous active-high reset
//   wr_ready                         : producer owns a bank
//   wr_en_*/wr_addr_*/wr_real_*/wr_imag_* : write ports A and B
//   wr_done                          : producer bank complete (pulse)
//   rd_avail                         : consumer owns a full bank
//   rd_en_*/rd_addr_*                : read request ports A and B
//   rd_real_*/rd_imag_*/rd_valid_*   : read data, READ_LATENCY after issue
//   rd_done                          : consumer finished its bank (pulse)
//   err_wr / err_rd                  : sticky protocol-error flags
// -----------------------------------------------------------------------------
module sfft_pingpong_buffer
    import sfft_buffer_pkg::*;
#(
    parameter int DATA_WIDTH   = SFFT_OUTPUT_WIDTH,
    parameter int ADDR_WIDTH   = 9,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  wr_ready,
    input  logic                  wr_en_A,
    input  logic                  wr_en_B,
    input  logic [ADDR_WIDTH-1:0] wr_addr_A,
    input  logic [ADDR_WIDTH-1:0] wr_addr_B,
    input  logic [DATA_WIDTH-1:0] wr_real_A,
    input  logic [DATA_WIDTH-1:0] wr_imag_A,
    input  logic [DATA_WIDTH-1:0] wr_real_B,
    input  logic [DATA_WIDTH-1:0] wr_imag_B,
    input  logic                  wr_done,
    output logic                  rd_avail,
    input  logic                  rd_en_A,
    input  logic                  rd_en_B,
    input  logic [ADDR_WIDTH-1:0] rd_addr_A,
    input  logic [ADDR_WIDTH-1:0] rd_addr_B,
    output logic [DATA_WIDTH-1:0] rd_real_A,
    output logic [DATA_WIDTH-1:0] rd_imag_A,
    output logic [DATA_WIDTH-1:0] rd_real_B,
    output logic [DATA_WIDTH-1:0] rd_imag_B,
    output logic                  rd_valid_A,
    output logic                  rd_valid_B,
    input  logic                  rd_done,
    output logic                  err_wr,
    output logic                  err_rd
);

    localparam int CW = 2 * DATA_WIDTH;

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("sfft_pingpong_buffer: READ_LATENCY must be 1 or 2");
    end

    bank_idx_t  wb_q, wb_d, rb_q, rb_d;
    logic [1:0] full_cnt_q, full_cnt_d;
    logic       err_wr_q, err_wr_d, err_rd_q, err_rd_d;
    logic       wr_acc, rd_acc;
    logic [1:0] rd_iss;
    logic [1:0] vld_p1_q;
    logic [CW-1:0] ram_rdata_a, ram_rdata_b;

    assign wr_ready = (full_cnt_q != 2'd2);
    assign rd_avail = (full_cnt_q != 2'd0);
    assign err_wr   = err_wr_q;
    assign err_rd   = err_rd_q;

    always_comb begin
        wr_acc     = wr_done & wr_ready;
        rd_acc     = rd_done & rd_avail;
        wb_d       = wb_q ^ wr_acc;
        rb_d       = rb_q ^ rd_acc;
        full_cnt_d = full_cnt_q;
        // Simultaneous accepted done pulses swap both banks and keep the count.
        if (wr_acc && !rd_acc)      full_cnt_d = full_cnt_q + 2'd1;
        else if (!wr_acc && rd_acc) full_cnt_d = full_cnt_q - 2'd1;
        err_wr_d = err_wr_q | (!wr_ready & (wr_en_A | wr_en_B | wr_done));
        err_rd_d = err_rd_q | (!rd_avail & (rd_en_A | rd_en_B | rd_done));
        rd_iss   = {rd_en_B & rd_avail, rd_en_A & rd_avail};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_q       <= '0;
            rb_q       <= '0;
            full_cnt_q <= '0;
            err_wr_q   <= 1'b0;
            err_rd_q   <= 1'b0;
        end else begin
            wb_q       <= wb_d;
            rb_q       <= rb_d;
            full_cnt_q <= full_cnt_d;
            err_wr_q   <= err_wr_d;
            err_rd_q   <= err_rd_d;
        end
    end

    // Bank bit is the address MSB; it is taken from the current indices at
    // issue, so writes/reads alongside an accepted done hit the old bank.
    complex_dp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH + 1)
    ) u_ram (
        .clk       (clk),
        .reset     (reset),
        .we_a_i    (wr_en_A & wr_ready),
        .waddr_a_i ({wb_q, wr_addr_A}),
        .wdata_a_i ({wr_real_A, wr_imag_A}),
        .we_b_i    (wr_en_B & wr_ready),
        .waddr_b_i ({wb_q, wr_addr_B}),
        .wdata_b_i ({wr_real_B, wr_imag_B}),
        .re_a_i    (rd_iss[0]),
        .raddr_a_i ({rb_q, rd_addr_A}),
        .rdata_a_o (ram_rdata_a),
        .re_b_i    (rd_iss[1]),
        .raddr_b_i ({rb_q, rd_addr_B}),
        .rdata_b_o (ram_rdata_b)
    );

    // ---- stage p1: RAM read register ----
    always_ff @(posedge clk) begin
        if (reset) vld_p1_q <= '0;
        else       vld_p1_q <= rd_iss;
    end

    if (READ_LATENCY == 2) begin : g_lat2
        // ---- stage p2: output register ----
        logic [1:0]    vld_p2_q;
        logic [CW-1:0] dat_a_p2_q, dat_b_p2_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                vld_p2_q   <= '0;
                dat_a_p2_q <= '0;
                dat_b_p2_q <= '0;
            end else begin
                vld_p2_q <= vld_p1_q;
                if (vld_p1_q[0]) dat_a_p2_q <= ram_rdata_a;
                if (vld_p1_q[1]) dat_b_p2_q <= ram_rdata_b;
            end
        end

        assign rd_valid_A             = vld_p2_q[0];
        assign rd_valid_B             = vld_p2_q[1];
        assign {rd_real_A, rd_imag_A} = dat_a_p2_q;
        assign {rd_real_B, rd_imag_B} = dat_b_p2_q;
    end else begin : g_lat1
        assign rd_valid_A             = vld_p1_q[0];
        assign rd_valid_B             = vld_p1_q[1];
        assign {rd_real_A, rd_imag_A} = ram_rdata_a;
        assign {rd_real_B, rd_imag_B} = ram_rdata_b;
    end

endmodule
